uart_cmd_tx: RTL and testbench

Transmit-side command serializer for the Segway UART link. It accepts a 16-bit command word and sends it over a single TX line as two 8N1 UART frames, high byte first, LSB first within each byte. It contains its own baud counter and shifter, with no dependency on a separate byte transmitter. It is the sending end for the receive path, which reassembles two received bytes into a command, and it also serves as the command source in loopback benches.

---
 rtl/uart_cmd_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_cmd_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serializes a 16-bit command as back-to-back 8N1 UART frames.
// Bytes go out high byte first, and each byte goes out LSB first.
// Optional feature macro: UART_CMD_CKSUM_EN adds a third frame that carries
// cmd[15:8] ^ cmd[7:0]. With the macro undefined, exactly two frames are sent.
//
//   state | meaning
//   IDLE  | line high; waiting for snd_cmd
//   XMIT  | shifting frames out, one bit every BAUD_DIV cycles
//   DONE  | single cycle; raises cmd_sent, then returns to IDLE
module uart_cmd_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'd9;
`ifdef UART_CMD_CKSUM_EN
  localparam logic [1:0]  LAST_IDX  = 2'd2;
`else
  localparam logic [1:0]  LAST_IDX  = 2'd1;
`endif

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [9:0]  shift_q, shift_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;

  logic [1:0]  next_idx;
  logic [7:0]  next_byte;
  logic        baud_tc;
  logic        frame_end;

  assign baud_tc   = (baud_q == BAUD_LAST);
  assign frame_end = (bit_q == BIT_LAST);

  // Pick the byte that follows the frame now in flight, taken from the holding register.
  always_comb begin
    next_idx = idx_q + 2'd1;
    case (next_idx)
      2'd1:    next_byte = hold_q[7:0];
`ifdef UART_CMD_CKSUM_EN
      2'd2:    next_byte = hold_q[15:8] ^ hold_q[7:0];
`endif
      default: next_byte = hold_q[15:8];
    endcase
  end

  // Next-state logic. The shifter always refills with 1s, so once the last
  // stop bit has gone out, the line sits high without any extra muxing.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    sent_d  = sent_q;

    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          hold_d  = cmd;
          shift_d = {1'b1, cmd[15:8], 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          sent_d  = 1'b0;
          state_d = XMIT;
        end
      end

      XMIT: begin
        if (baud_tc) begin
          baud_d = '0;
          if (frame_end) begin
            bit_d = '0;
            if (idx_q != LAST_IDX) begin
              // Start bit of the next frame follows the stop bit directly.
              shift_d = {1'b1, next_byte, 1'b0};
              idx_d   = next_idx;
            end else begin
              shift_d = '1;
              busy_d  = 1'b0;
              state_d = DONE;
            end
          end else begin
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end

      DONE: begin
        sent_d  = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. A synchronous reset drives the line high on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  assign TX       = shift_q[0];
  assign busy     = busy_q;
  assign cmd_sent = sent_q;

`ifndef SYNTHESIS
  // Counters never pass their terminal values, and the line is high whenever the FSM is idle.
  a_baud_range: assert property (@(posedge clk) disable iff (rst) baud_q <= BAUD_LAST);
  a_bit_range:  assert property (@(posedge clk) disable iff (rst) bit_q <= BIT_LAST);
  a_idle_high:  assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> TX);
`endif

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx with BAUD_DIV=8; a bit-level receiver model decodes TX.
module tb_uart_cmd_tx;

  localparam int BD = 8;
  localparam int FR = 10 * BD;
`ifdef UART_CMD_CKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int CMD_LEN = NB * FR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        TX;
  logic        busy;
  logic        cmd_sent;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          rises = 0;
  logic        sent_prev = 1'b0;
  logic [7:0]  rx_q[$];

  uart_cmd_tx #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .TX       (TX),
    .busy     (busy),
    .cmd_sent (cmd_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_sent === 1'b1 && sent_prev !== 1'b1) rises++;
    sent_prev = cmd_sent;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receive one 8N1 byte: find the start bit, then sample each bit at its middle.
  task automatic rx_byte();
    logic [7:0] b;
    int w;
    b = '0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (TX !== 1'b0 && w < 4 * CMD_LEN);
    if (TX !== 1'b0) begin
      check_val("rx_start_seen", 32'(TX), 0);
      return;
    end
    repeat (BD / 2) @(negedge clk);
    check_val("rx_start_mid", 32'(TX), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BD) @(negedge clk);
    check_val("rx_stop", 32'(TX), 1);
    rx_q.push_back(b);
  endtask

  task automatic wait_not_busy(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 4 * CMD_LEN) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int lows;
    int busys;
    lows  = 0;
    busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check_val({tag, "_tx_low_cycles"}, lows, 0);
    check_val({tag, "_busy_cycles"}, busys, 0);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    logic [7:0] e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    check_val({tag, "_nbytes"}, rx_q.size(), NB);
    for (int i = 0; i < NB && i < rx_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(e[i]));
  endtask

  initial begin
    int bc;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(TX), 1);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_sent", 32'(cmd_sent), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single pulse, 16'h55AA; measure acceptance latency, busy length, cmd_sent
    rx_q.delete();
    rises = 0;
    cmd = 16'h55AA;
    snd_cmd = 1'b1;
    fork
      repeat (NB) rx_byte();
      begin
        @(negedge clk);
        snd_cmd = 1'b0;
        check_val("t1_tx_start", 32'(TX), 0);
        check_val("t1_busy_on", 32'(busy), 1);
        check_val("t1_sent_clr", 32'(cmd_sent), 0);
        bc = 1;
        while (busy === 1'b1 && bc < 4 * CMD_LEN) begin
          @(negedge clk);
          if (busy === 1'b1) bc++;
        end
        check_val("t1_busy_len", bc, CMD_LEN);
        check_val("t1_done_tx", 32'(TX), 1);
        check_val("t1_done_sent", 32'(cmd_sent), 0);
        @(negedge clk);
        check_val("t1_sent_set", 32'(cmd_sent), 1);
        check_val("t1_busy_off", 32'(busy), 0);
      end
    join
    watch_quiet("t1_after", 2 * FR);
    check_val("t1_rises", rises, 1);
    check_bytes("t1", 8'h55, 8'hAA, 8'hFF);

    // 2: snd_cmd pulses while busy must be ignored
    rx_q.delete();
    rises = 0;
    cmd = 16'hF00F;
    snd_cmd = 1'b1;
    fork
      repeat (NB) rx_byte();
      begin
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (19) @(negedge clk);
        cmd = 16'h1111;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (79) @(negedge clk);
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        wait_not_busy(bc);
        check_val("t2_busy_drop", 32'(busy), 0);
      end
    join
    watch_quiet("t2_after", 3 * FR);
    check_val("t2_rises", rises, 1);
    check_bytes("t2", 8'hF0, 8'h0F, 8'hFF);

    // 3: cmd changes right after acceptance (also the checksum vector 12^34=26)
    rx_q.delete();
    rises = 0;
    cmd = 16'h1234;
    snd_cmd = 1'b1;
    fork
      repeat (NB) rx_byte();
      begin
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 16'hFFFF;
        wait_not_busy(bc);
        check_val("t3_busy_len", bc, CMD_LEN);
      end
    join
    repeat (3) @(negedge clk);
    check_val("t3_rises", rises, 1);
    check_bytes("t3", 8'h12, 8'h34, 8'h26);

    // 4: reset mid-frame, then a clean send
    cmd = 16'hA5A5;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check_val("t4_busy_on", 32'(busy), 1);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t4_rst_tx", 32'(TX), 1);
    check_val("t4_rst_busy", 32'(busy), 0);
    check_val("t4_rst_sent", 32'(cmd_sent), 0);
    rst = 1'b0;
    rises = 0;
    watch_quiet("t4_post_rst", 2 * FR);
    check_val("t4_rises_rst", rises, 0);
    rx_q.delete();
    cmd = 16'h0001;
    snd_cmd = 1'b1;
    fork
      repeat (NB) rx_byte();
      begin
        @(negedge clk);
        snd_cmd = 1'b0;
        wait_not_busy(bc);
        check_val("t4_busy_len", bc, CMD_LEN);
        @(negedge clk);
        check_val("t4_sent_set", 32'(cmd_sent), 1);
      end
    join
    repeat (2) @(negedge clk);
    check_bytes("t4", 8'h00, 8'h01, 8'h01);

    // 5: snd_cmd held high -> back-to-back commands two cycles after each last stop bit
    rx_q.delete();
    rises = 0;
    cmd = 16'h00FF;
    snd_cmd = 1'b1;
    fork
      repeat (2 * NB) rx_byte();
      begin
        for (int k = 0; k <= 2 * CMD_LEN + 4; k++) begin
          @(negedge clk);
          if (k == CMD_LEN - 1) begin
            check_val("t5_last_stop_tx", 32'(TX), 1);
            check_val("t5_last_stop_busy", 32'(busy), 1);
          end
          if (k == CMD_LEN) begin
            check_val("t5_done_busy", 32'(busy), 0);
            check_val("t5_done_tx", 32'(TX), 1);
          end
          if (k == CMD_LEN + 1) begin
            check_val("t5_idle_tx", 32'(TX), 1);
            check_val("t5_idle_sent", 32'(cmd_sent), 1);
          end
          if (k == CMD_LEN + 2) begin
            check_val("t5_restart_tx", 32'(TX), 0);
            check_val("t5_restart_busy", 32'(busy), 1);
            check_val("t5_restart_sent", 32'(cmd_sent), 0);
          end
          if (k == 2 * CMD_LEN + 3) check_val("t5_idle2_tx", 32'(TX), 1);
          if (k == 2 * CMD_LEN + 4) check_val("t5_restart2_tx", 32'(TX), 0);
        end
        snd_cmd = 1'b0;
        wait_not_busy(bc);
        repeat (2) @(negedge clk);
      end
    join
    repeat (2) @(negedge clk);
    check_val("t5_rises", rises, 3);
    check_val("t5_nbytes", rx_q.size(), 2 * NB);
    for (int i = 0; i < 2 * NB && i < rx_q.size(); i++)
      check_val($sformatf("t5_byte%0d", i), 32'(rx_q[i]), (i % NB == 0) ? 32'h00 : 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
